// File: rtl/sysid_check_ctrl_if.sv
// ---------------------------------------------------------------------------
// sysid_check_ctrl_if
// Avalon-MM read-only link between the boot-time ID checker (master) and the
// system ID peripheral control slave.
//   avm_address     : word address (0 = ID word, 1 = build timestamp)
//   avm_read        : read strobe
//   avm_readdata    : 32-bit read data from the slave
//   avm_waitrequest : slave stall, transfer completes when low with read high
// ---------------------------------------------------------------------------
interface sysid_check_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_check_ctrl.sv
// ---------------------------------------------------------------------------
// sysid_check_ctrl
// Boot-time sequencer: reads the system ID word (address 0) and the build
// timestamp word (address 1) from the system ID peripheral, compares them to
// the build-time expected values and reports pass/fail to the boot logic.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset (sync release)
//   start          : single-cycle request to run a check (ignored while busy)
//   busy           : check in progress
//   done           : check finished, held until next accepted start or reset
//   pass           : valid while done; ID ok, TS ok (or not checked), no timeout
//   id_err, ts_err : word mismatch flags (ts_err set regardless of CHECK_TS)
//   timeout_err    : read retries exhausted
//   id_value       : captured ID word
//   ts_value       : captured timestamp word
//   avm            : Avalon-MM read-only master port
// ---------------------------------------------------------------------------
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd1665219701,
  parameter logic [31:0] EXPECTED_TS    = 32'd1375634013,
  parameter bit          CHECK_TS       = 1'b1,
  parameter bit          AUTO_START     = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRY      = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      id_err,
  output logic                      ts_err,
  output logic                      timeout_err,
  output logic [31:0]               id_value,
  output logic [31:0]               ts_value,
  sysid_check_ctrl_if.master        avm
);

  // Stall count value at which the current attempt is abandoned.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CMP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_auto;        // pending automatic check after reset release
  logic        r_gap;         // one-cycle read drop between retry attempts
  logic [7:0]  r_stall;
  logic [2:0]  r_retry;
  logic        r_pass;
  logic        r_id_err;
  logic        r_ts_err;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic w_rd_state;
  logic w_read;
  logic w_xfer;
  logic w_stalled;
  logic w_to_hit;
  logic w_give_up;
  logic w_accept;
  logic w_id_mis;
  logic w_ts_mis;

  assign w_rd_state = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_read     = w_rd_state && !r_gap;
  assign w_xfer     = w_read && !avm.avm_waitrequest;
  assign w_stalled  = w_read && avm.avm_waitrequest;
  assign w_to_hit   = w_stalled && (r_stall == TO_LAST);
  // The retry budget is shared by both reads, so the last timeout ends the check.
  assign w_give_up  = w_to_hit && (r_retry == RETRY_MAX);
  assign w_accept   = ((r_state == S_IDLE) && (start || r_auto)) ||
                      ((r_state == S_DONE) && start);
  assign w_id_mis   = (r_id_value != EXPECTED_ID);
  assign w_ts_mis   = (r_ts_value != EXPECTED_TS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    busy            = 1'b0;
    done            = 1'b0;
    avm.avm_read    = w_read;
    avm.avm_address = (r_state == S_RD_TS);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_RD_ID;
      end
      S_RD_ID: begin
        busy = 1'b1;
        if (w_give_up)   w_state_next = S_DONE;
        else if (w_xfer) w_state_next = S_RD_TS;
      end
      S_RD_TS: begin
        busy = 1'b1;
        if (w_give_up)   w_state_next = S_DONE;
        else if (w_xfer) w_state_next = S_CMP;
      end
      S_CMP: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (w_accept) w_state_next = S_RD_ID;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto     <= AUTO_START;
      r_gap      <= 1'b0;
      r_stall    <= 8'd0;
      r_retry    <= 3'd0;
      r_pass     <= 1'b0;
      r_id_err   <= 1'b0;
      r_ts_err   <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else begin
      if (w_accept) r_auto <= 1'b0;

      // A timed-out attempt drops the strobe for one cycle, then reissues.
      r_gap   <= w_to_hit && !w_give_up;
      r_stall <= (w_stalled && !w_to_hit) ? r_stall + 8'd1 : 8'd0;

      if (w_accept) begin
        r_retry <= 3'd0;
      end else if (w_to_hit && !w_give_up) begin
        r_retry <= r_retry + 3'd1;
      end

      if (w_xfer && (r_state == S_RD_ID)) r_id_value <= avm.avm_readdata;
      if (w_xfer && (r_state == S_RD_TS)) r_ts_value <= avm.avm_readdata;

      if (w_accept) begin
        r_pass    <= 1'b0;
        r_id_err  <= 1'b0;
        r_ts_err  <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_give_up) begin
        r_timeout <= 1'b1;
      end else if (r_state == S_CMP) begin
        r_id_err <= w_id_mis;
        r_ts_err <= w_ts_mis;
        r_pass   <= !w_id_mis && (!w_ts_mis || (CHECK_TS == 1'b0));
      end
    end
  end

  assign pass        = r_pass;
  assign id_err      = r_id_err;
  assign ts_err      = r_ts_err;
  assign timeout_err = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'd1665219701;
  localparam logic [31:0] EXP_TS = 32'd1375634013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start;
  logic [1:0]  busy, done, pass, id_err, ts_err, to_err;
  logic [31:0] idv [2];
  logic [31:0] tsv [2];

  sysid_check_ctrl_if if_a ();
  sysid_check_ctrl_if if_b ();

  // Instance A: default build (TS checked, long timeout, 3 retries).
  sysid_check_ctrl #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1),
    .AUTO_START(1'b1), .TIMEOUT_CYCLES(255), .MAX_RETRY(3)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .id_err(id_err[0]), .ts_err(ts_err[0]), .timeout_err(to_err[0]),
    .id_value(idv[0]), .ts_value(tsv[0]), .avm(if_a)
  );

  // Instance B: TS ignored for pass, short timeout, 1 retry.
  sysid_check_ctrl #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0),
    .AUTO_START(1'b1), .TIMEOUT_CYCLES(4), .MAX_RETRY(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .id_err(id_err[1]), .ts_err(ts_err[1]), .timeout_err(to_err[1]),
    .id_value(idv[1]), .ts_value(tsv[1]), .avm(if_b)
  );

  // Slave model: each attempt on an address stalls for cfg_w* cycles.
  logic [31:0] cfg_id, cfg_ts;
  int          cfg_wid, cfg_wts;
  logic [1:0]  rd, adr, wr;
  int          scnt [2] = '{0, 0};

  assign rd[0] = if_a.avm_read;
  assign rd[1] = if_b.avm_read;
  assign adr[0] = if_a.avm_address;
  assign adr[1] = if_b.avm_address;
  assign if_a.avm_waitrequest = wr[0];
  assign if_b.avm_waitrequest = wr[1];
  assign if_a.avm_readdata = adr[0] ? cfg_ts : cfg_id;
  assign if_b.avm_readdata = adr[1] ? cfg_ts : cfg_id;

  always_comb begin
    wr = 2'b00;
    for (int d = 0; d < 2; d++)
      wr[d] = rd[d] && (scnt[d] < (adr[d] ? cfg_wts : cfg_wid));
  end

  // Bus monitor: completed transfers, strobe drops after a stall, protocol violations.
  int         xfers [2] = '{0, 0};
  int         drops [2] = '{0, 0};
  int         viol  [2] = '{0, 0};
  logic [1:0] prev_stall = 2'b00;
  logic [1:0] prev_drop  = 2'b00;
  logic [1:0] prev_adr   = 2'b00;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd[d] && !wr[d])  scnt[d] <= 0;
      else if (rd[d])       scnt[d] <= scnt[d] + 1;
      else                  scnt[d] <= 0;
      if (reset_n) begin
        if (rd[d] && !wr[d]) xfers[d] <= xfers[d] + 1;
        if (prev_stall[d] && !rd[d]) drops[d] <= drops[d] + 1;
        if (prev_stall[d] && rd[d] && (adr[d] != prev_adr[d])) viol[d] <= viol[d] + 1;
        if (prev_drop[d] && !rd[d] && !done[d]) viol[d] <= viol[d] + 1;
      end
      prev_stall[d] <= reset_n && rd[d] && wr[d];
      prev_drop[d]  <= reset_n && prev_stall[d] && !rd[d];
      prev_adr[d]   <= adr[d];
    end
  end

  int    n_cmp = 0;
  int    n_mis = 0;
  string cur_test;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: words held by each instance from earlier checks.
  logic [31:0] m_id [2];
  logic [31:0] m_ts [2];

  // Outcome of one check from the current slave configuration.
  task automatic ref_model(input int d, output int t, output logic p, output logic ie,
                           output logic te, output logic to, output logic [31:0] iv,
                           output logic [31:0] tv, output int xf, output int dr);
    int tmo, mr, w, r;
    bit chk;
    tmo = (d == 0) ? 255 : 4;
    mr  = (d == 0) ? 3 : 1;
    chk = (d == 0);
    t = 1; r = 0; to = 1'b0; xf = 0; dr = 0;
    iv = m_id[d]; tv = m_ts[d];
    for (int k = 0; k < 2 && !to; k++) begin
      w = (k == 0) ? cfg_wid : cfg_wts;
      forever begin
        if (w < tmo) begin
          t += w + 1; xf++;
          if (k == 0) iv = cfg_id; else tv = cfg_ts;
          break;
        end else if (r == mr) begin
          to = 1'b1; dr++; t += tmo;
          break;
        end else begin
          r++; dr++; t += tmo + 1;
        end
      end
    end
    if (to) begin
      p = 1'b0; ie = 1'b0; te = 1'b0;
    end else begin
      t += 1;
      ie = (iv != EXP_ID);
      te = (tv != EXP_TS);
      p  = !ie && (!te || !chk);
    end
  endtask

  task automatic run_check(input bit use_reset, input int pulse_at);
    int          et [2], ex [2], ed [2], x0 [2], d0 [2], v0 [2], first [2];
    logic        ep [2], eie [2], ete [2], eto [2];
    logic [31:0] eiv [2], etv [2];
    int          cyc;
    string       pf;
    if (use_reset) begin
      m_id = '{32'd0, 32'd0};
      m_ts = '{32'd0, 32'd0};
    end
    for (int d = 0; d < 2; d++) begin
      ref_model(d, et[d], ep[d], eie[d], ete[d], eto[d], eiv[d], etv[d], ex[d], ed[d]);
      x0[d] = xfers[d]; d0[d] = drops[d]; v0[d] = viol[d]; first[d] = -1;
    end
    if (use_reset) begin
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
    end else begin
      start = 1'b1;
    end
    cyc = 0;
    while (cyc < 3000 && (first[0] < 0 || first[1] < 0)) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == pulse_at);
      for (int d = 0; d < 2; d++) begin
        pf = {cur_test, (d == 0) ? ".A." : ".B."};
        if (cyc == 1) begin
          check_value({pf, "busy_c1"}, 32'(busy[d]), 32'd1);
          check_value({pf, "done_c1"}, 32'(done[d]), 32'd0);
          check_value({pf, "pass_c1"}, 32'(pass[d]), 32'd0);
        end
        if (done[d] && first[d] < 0) first[d] = cyc;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      pf = {cur_test, (d == 0) ? ".A." : ".B."};
      check_value({pf, "done_cycle"}, 32'(first[d]), 32'(et[d]));
      check_value({pf, "done_held"}, 32'(done[d]), 32'd1);
      check_value({pf, "busy"}, 32'(busy[d]), 32'd0);
      check_value({pf, "pass"}, 32'(pass[d]), 32'(ep[d]));
      check_value({pf, "id_err"}, 32'(id_err[d]), 32'(eie[d]));
      check_value({pf, "ts_err"}, 32'(ts_err[d]), 32'(ete[d]));
      check_value({pf, "timeout_err"}, 32'(to_err[d]), 32'(eto[d]));
      check_value({pf, "id_value"}, idv[d], eiv[d]);
      check_value({pf, "ts_value"}, tsv[d], etv[d]);
      check_value({pf, "transfers"}, 32'(xfers[d] - x0[d]), 32'(ex[d]));
      check_value({pf, "read_drops"}, 32'(drops[d] - d0[d]), 32'(ed[d]));
      check_value({pf, "bus_rule"}, 32'(viol[d] - v0[d]), 32'd0);
      m_id[d] = eiv[d];
      m_ts[d] = etv[d];
      $display("%s: %s done@%0d pass=%0d id_err=%0d ts_err=%0d to=%0d id=%0d ts=%0d",
               cur_test, (d == 0) ? "A" : "B", first[d], pass[d], id_err[d], ts_err[d],
               to_err[d], idv[d], tsv[d]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_value({tag, ".flags"},
                  32'({busy[d], done[d], pass[d], id_err[d], ts_err[d], to_err[d]}), 32'd0);
      check_value({tag, ".avm_read"}, 32'(rd[d]), 32'd0);
      check_value({tag, ".id_value"}, idv[d], 32'd0);
      check_value({tag, ".ts_value"}, tsv[d], 32'd0);
    end
  endtask

  task automatic set_cfg(input logic [31:0] id, input logic [31:0] ts, input int wi, input int wt);
    cfg_id = id; cfg_ts = ts; cfg_wid = wi; cfg_wts = wt;
  endtask

  function automatic logic [31:0] rand_word(input logic [31:0] good);
    logic [31:0] bitmask;
    bitmask = 32'd1 << $urandom_range(0, 31);
    case ($urandom_range(0, 3))
      0, 1:    return good;
      2:       return good ^ bitmask;
      default: return ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom());
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    set_cfg(EXP_ID, EXP_TS, 0, 0);
    m_id = '{32'd0, 32'd0};
    m_ts = '{32'd0, 32'd0};
    repeat (3) @(posedge clk);
    #1;
    cur_test = "reset_state";
    check_all_zero(cur_test);

    cur_test = "auto_start";
    run_check(1'b1, 0);

    cur_test = "id_mismatch";
    set_cfg(EXP_ID - 32'd1, EXP_TS, 0, 0);
    run_check(1'b0, 0);

    cur_test = "ts_zero";
    set_cfg(EXP_ID, 32'd0, 0, 0);
    run_check(1'b0, 0);

    cur_test = "ts_stuck";
    set_cfg(EXP_ID, EXP_TS, 0, 100000);
    run_check(1'b0, 0);

    cur_test = "wait3";
    set_cfg(EXP_ID, EXP_TS, 3, 3);
    run_check(1'b0, 0);

    cur_test = "start_busy";
    set_cfg(EXP_ID, EXP_TS, 2, 1);
    run_check(1'b0, 2);

    cur_test = "reset_abort";
    set_cfg(EXP_ID, EXP_TS, 0, 20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero(cur_test);
    cur_test = "recheck";
    run_check(1'b1, 0);

    for (int i = 0; i < 14; i++) begin
      cur_test = $sformatf("rand%0d", i);
      set_cfg(rand_word(EXP_ID), rand_word(EXP_TS),
              ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : 100000,
              ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : 100000);
      run_check($urandom_range(0, 3) == 0, ($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
